// File: rtl/jogo_pkg.sv
// ============================================================================
// Module   : jogo_pkg
// Purpose  : Shared types and helpers for the sequence-memory game core.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package jogo_pkg;

    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        PREPARA        = 4'h1,
        EXIBE_LED      = 4'h2,
        EXIBE_PAUSA    = 4'h3,
        INICIA_ENTRADA = 4'h4,
        ESPERA         = 4'h5,
        REGISTRA       = 4'h6,
        COMPARA        = 4'h7,
        PROX_JOGADA    = 4'h8,
        PROX_RODADA    = 4'h9,
        GANHOU         = 4'hA,
        PERDEU         = 4'hE
    } estado_t;

    // Feedback taps b15, b13, b12, b10.
    localparam logic [15:0] c_lfsr_taps = 16'hB400;

    // One-hot element selected by the low log2n bits of the LFSR state.
    function automatic logic [7:0] elemento(input logic [15:0] lfsr,
                                            input int unsigned log2n);
        logic [2:0] mascara;
        mascara = 3'((8'd1 << log2n) - 8'd1);
        return 8'd1 << (lfsr[2:0] & mascara);
    endfunction

endpackage

`default_nettype wire

// File: rtl/jogo_sequencia_param_lfsr16.sv
// ============================================================================
// Module   : lfsr16
// Purpose  : 16-bit shift-left Fibonacci LFSR; reset > carrega > avanca.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr16
    import jogo_pkg::*;
#(
    parameter logic [15:0] SEMENTE = 16'h0001
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        carrega,
    input  logic        avanca,
    output logic [15:0] estado
);

    logic [15:0] estado_q;
    logic [15:0] estado_d;

    always_comb begin
        estado_d = estado_q;
        if (carrega) begin
            estado_d = SEMENTE;
        end else if (avanca) begin
            estado_d = {estado_q[14:0], ^(estado_q & c_lfsr_taps)};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= SEMENTE;
        end else begin
            estado_q <= estado_d;
        end
    end

    assign estado = estado_q;

endmodule

`default_nettype wire

// File: rtl/jogo_sequencia_param.sv
// ============================================================================
// Module   : jogo_sequencia_param
// Purpose  : Parametrised sequence-memory game core (display, input, timeout).
//            JOGO_EXIBE_SEQ_EN compiles in the LED display phase.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module jogo_sequencia_param
    import jogo_pkg::*;
#(
    parameter int unsigned N_BOTOES  = 4,
    parameter int unsigned N_RODADAS = 16,
    parameter int unsigned T_INATIVO = 5000,
    parameter int unsigned T_LED     = 1000,
    parameter int unsigned T_PAUSA   = 250,
    parameter logic [15:0] SEMENTE   = 16'h0001
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                jogar,
    input  logic [N_BOTOES-1:0] botoes,
    output logic [N_BOTOES-1:0] leds,
    output logic                pronto,
    output logic                ganhou,
    output logic                perdeu,
    output logic                db_timeout,
    output logic                db_igual,
    output logic [3:0]          db_estado,
    output logic [3:0]          db_rodada,
    output logic [3:0]          db_jogada,
    output logic [3:0]          db_contagem_inativo
);

    localparam int unsigned c_log2n = (N_BOTOES > 1) ? $clog2(N_BOTOES) : 1;
    localparam int unsigned c_rw    = (N_RODADAS > 1) ? $clog2(N_RODADAS) : 1;
    localparam int unsigned c_iw    = $clog2(T_INATIVO + 1);

    localparam logic [c_rw-1:0] c_ultima      = c_rw'(N_RODADAS - 1);
    localparam logic [c_iw-1:0] c_inativo_fim = c_iw'(T_INATIVO - 1);

`ifdef JOGO_EXIBE_SEQ_EN
    localparam estado_t c_inicio_rodada = EXIBE_LED;
    localparam int unsigned c_tw = $clog2(((T_LED > T_PAUSA) ? T_LED : T_PAUSA) + 1);
    localparam logic [c_tw-1:0] c_led_fim   = c_tw'(T_LED - 1);
    localparam logic [c_tw-1:0] c_pausa_fim = c_tw'(T_PAUSA - 1);

    logic [c_tw-1:0] tempo_q;
    logic [c_tw-1:0] tempo_d;
`else
    localparam estado_t c_inicio_rodada = INICIA_ENTRADA;
`endif

    estado_t             estado_q;
    estado_t             estado_d;
    logic [c_rw-1:0]     rodada_q;
    logic [c_rw-1:0]     rodada_d;
    logic [c_rw-1:0]     jogada_q;
    logic [c_rw-1:0]     jogada_d;
    logic [c_iw-1:0]     inativo_q;
    logic [c_iw-1:0]     inativo_d;
    logic [N_BOTOES-1:0] botoes_q;
    logic [N_BOTOES-1:0] lance_q;
    logic [N_BOTOES-1:0] lance_d;
    logic                igual_q;
    logic                igual_d;
    logic                timeout_q;
    logic                timeout_d;

    logic [15:0]         w_lfsr;
    logic                w_carrega;
    logic                w_avanca;
    logic [N_BOTOES-1:0] w_esperado;
    logic                w_press;
    logic                w_igual;

    lfsr16 #(
        .SEMENTE (SEMENTE)
    ) u_lfsr (
        .clock   (clock),
        .reset   (reset),
        .carrega (w_carrega),
        .avanca  (w_avanca),
        .estado  (w_lfsr)
    );

    assign w_esperado = N_BOTOES'(elemento(w_lfsr, c_log2n));
    // botoes_q holds last cycle's buttons: a press needs an all-released cycle first.
    assign w_press    = (estado_q == ESPERA) && (|botoes) && !(|botoes_q);
    assign w_igual    = (lance_q == w_esperado);

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= INICIAL;
        end else begin
            estado_q <= estado_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            INICIAL:        if (jogar) estado_d = PREPARA;
            PREPARA:        estado_d = c_inicio_rodada;
`ifdef JOGO_EXIBE_SEQ_EN
            EXIBE_LED:      if (tempo_q == c_led_fim) estado_d = EXIBE_PAUSA;
            EXIBE_PAUSA:    if (tempo_q == c_pausa_fim)
                                estado_d = (jogada_q < rodada_q) ? EXIBE_LED : INICIA_ENTRADA;
`endif
            INICIA_ENTRADA: estado_d = ESPERA;
            ESPERA: begin
                if (w_press)                         estado_d = REGISTRA;
                else if (inativo_q == c_inativo_fim) estado_d = PERDEU;
            end
            REGISTRA:       estado_d = COMPARA;
            COMPARA: begin
                if (!w_igual)                estado_d = PERDEU;
                else if (jogada_q < rodada_q) estado_d = PROX_JOGADA;
                else                          estado_d = PROX_RODADA;
            end
            PROX_JOGADA:    estado_d = ESPERA;
            PROX_RODADA:    estado_d = (rodada_q == c_ultima) ? GANHOU : c_inicio_rodada;
            GANHOU, PERDEU: if (jogar) estado_d = PREPARA;
            default:        estado_d = INICIAL;
        endcase
    end

    always_comb begin
        leds = '0;
`ifdef JOGO_EXIBE_SEQ_EN
        if (estado_q == EXIBE_LED) leds = w_esperado;
`else
        if (estado_q == ESPERA) leds = w_esperado;
`endif
        ganhou = (estado_q == GANHOU);
        perdeu = (estado_q == PERDEU);
        pronto = (estado_q == GANHOU) || (estado_q == PERDEU);
    end

    always_comb begin
        rodada_d  = rodada_q;
        jogada_d  = jogada_q;
        lance_d   = lance_q;
        igual_d   = igual_q;
        timeout_d = timeout_q;
        inativo_d = (estado_q == ESPERA) ? inativo_q + 1'b1 : '0;
        w_carrega = 1'b0;
        w_avanca  = 1'b0;
`ifdef JOGO_EXIBE_SEQ_EN
        tempo_d   = (estado_d != estado_q) ? '0 : tempo_q + 1'b1;
`endif
        case (estado_q)
            PREPARA: begin
                rodada_d  = '0;
                jogada_d  = '0;
                lance_d   = '0;
                igual_d   = 1'b0;
                timeout_d = 1'b0;
                w_carrega = 1'b1;
            end
`ifdef JOGO_EXIBE_SEQ_EN
            EXIBE_PAUSA: begin
                if (estado_d == EXIBE_LED) begin
                    jogada_d = jogada_q + 1'b1;
                    w_avanca = 1'b1;
                end
            end
`endif
            INICIA_ENTRADA: begin
                jogada_d  = '0;
                w_carrega = 1'b1;
            end
            ESPERA:   if (estado_d == PERDEU) timeout_d = 1'b1;
            REGISTRA: lance_d = botoes_q;
            COMPARA:  igual_d = w_igual;
            PROX_JOGADA: begin
                jogada_d = jogada_q + 1'b1;
                w_avanca = 1'b1;
            end
            PROX_RODADA: begin
                if (estado_d != GANHOU) begin
                    rodada_d  = rodada_q + 1'b1;
                    jogada_d  = '0;
                    w_carrega = 1'b1;
                end
            end
            GANHOU, PERDEU: begin
                if (jogar) begin
                    igual_d   = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rodada_q  <= '0;
            jogada_q  <= '0;
            inativo_q <= '0;
            botoes_q  <= '0;
            lance_q   <= '0;
            igual_q   <= 1'b0;
            timeout_q <= 1'b0;
`ifdef JOGO_EXIBE_SEQ_EN
            tempo_q   <= '0;
`endif
        end else begin
            rodada_q  <= rodada_d;
            jogada_q  <= jogada_d;
            inativo_q <= inativo_d;
            botoes_q  <= botoes;
            lance_q   <= lance_d;
            igual_q   <= igual_d;
            timeout_q <= timeout_d;
`ifdef JOGO_EXIBE_SEQ_EN
            tempo_q   <= tempo_d;
`endif
        end
    end

    assign db_estado  = estado_q;
    assign db_rodada  = 4'(rodada_q);
    assign db_jogada  = 4'(jogada_q);
    assign db_timeout = timeout_q;
    assign db_igual   = igual_q;

    generate
        if (c_iw >= 4) begin : g_cont_alto
            assign db_contagem_inativo = inativo_q[c_iw-1 -: 4];
        end else begin : g_cont_baixo
            assign db_contagem_inativo = 4'(inativo_q);
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_jogo_sequencia_param.sv
// ============================================================================
// Module   : tb_jogo_sequencia_param
// Purpose  : Self-checking bench for jogo_sequencia_param (both display builds).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_jogo_sequencia_param;

    localparam int unsigned N_BOTOES  = 4;
    localparam int unsigned N_RODADAS = 3;
    localparam int unsigned T_INATIVO = 20;
    localparam int unsigned T_LED     = 5;
    localparam int unsigned T_PAUSA   = 3;

    logic       clock = 1'b0;
    logic       reset;
    logic       jogar;
    logic [3:0] botoes;
    logic [3:0] leds;
    logic       pronto, ganhou, perdeu, db_timeout, db_igual;
    logic [3:0] db_estado, db_rodada, db_jogada, db_contagem_inativo;

    jogo_sequencia_param #(
        .N_BOTOES  (N_BOTOES),
        .N_RODADAS (N_RODADAS),
        .T_INATIVO (T_INATIVO),
        .T_LED     (T_LED),
        .T_PAUSA   (T_PAUSA),
        .SEMENTE   (16'h0001)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .jogar               (jogar),
        .botoes              (botoes),
        .leds                (leds),
        .pronto              (pronto),
        .ganhou              (ganhou),
        .perdeu              (perdeu),
        .db_timeout          (db_timeout),
        .db_igual            (db_igual),
        .db_estado           (db_estado),
        .db_rodada           (db_rodada),
        .db_jogada           (db_jogada),
        .db_contagem_inativo (db_contagem_inativo)
    );

    always #5 clock = ~clock;

    // Sequence for seed 1 with four buttons.
    logic [3:0] seq [3] = '{4'b0010, 4'b0100, 4'b0001};

    int unsigned n_verif  = 0;
    int unsigned n_falhas = 0;
    int unsigned ciclo    = 0;

    always @(posedge clock) ciclo <= ciclo + 1;

    typedef struct {
        logic [3:0]  estado;
        logic        igual;
        int unsigned ciclo;
    } veredito_t;

    veredito_t sb [$];

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_verif++;
        if (obs !== esp) begin
            n_falhas++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, esp);
        end
    endtask

    // Verdict monitor: the cycle after COMPARA must match the oldest pending press.
    logic [3:0] estado_ant = 4'h0;
    always @(negedge clock) begin : monitor
        veredito_t v;
        if (estado_ant == 4'h7 && db_estado !== 4'h7) begin
            if (sb.size() == 0) begin
                verifica("veredito_inesperado", 32'(db_estado), 32'hFF);
            end else begin
                v = sb.pop_front();
                verifica("veredito_estado", 32'(db_estado), 32'(v.estado));
                verifica("veredito_igual",  32'(db_igual),  32'(v.igual));
                verifica("veredito_ciclo",  ciclo,          v.ciclo);
            end
        end
        estado_ant = db_estado;
    end

    task automatic ciclos(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic espera_estado(input logic [3:0] e, input string tag);
        int n = 0;
        while (db_estado !== e && n < 2000) begin
            @(negedge clock);
            n++;
        end
        if (db_estado !== e) verifica(tag, 32'(db_estado), 32'(e));
    endtask

    task automatic aplica_reset(input string tag);
        reset  = 1'b1;
        jogar  = 1'b0;
        botoes = 4'b0000;
        ciclos(1);
        verifica(tag, {7'd0, leds, pronto, ganhou, perdeu, db_timeout, db_igual,
                       db_estado, db_rodada, db_jogada, db_contagem_inativo}, 32'd0);
        reset = 1'b0;
    endtask

    task automatic inicia_jogo();
        jogar = 1'b1;
        ciclos(1);
        verifica("estado_prepara", 32'(db_estado), 32'd1);
        jogar = 1'b0;
    endtask

    task automatic exibe_rodada(input int r);
`ifdef JOGO_EXIBE_SEQ_EN
        for (int j = 0; j <= r; j++) begin
            int n = 0;
            espera_estado(4'h2, "espera_exibe");
            if (j == 0) verifica("rodada_exibe", 32'(db_rodada), 32'(r));
            verifica("leds_exibe", 32'(leds), 32'(seq[j]));
            while (db_estado === 4'h2 && n < 100) begin
                @(negedge clock);
                n++;
            end
            verifica("duracao_led", n, T_LED);
            verifica("leds_pausa", 32'(leds), 32'd0);
        end
`else
        if (r < 0) verifica("rodada_negativa", 32'(r), 32'd0);
`endif
    endtask

    task automatic pressiona(input logic [3:0] val, input logic [3:0] esp_estado,
                             input logic esp_igual, input logic [3:0] elem);
        int n = 0;
        espera_estado(4'h5, "espera_entrada");
`ifndef JOGO_EXIBE_SEQ_EN
        verifica("leds_espera", 32'(leds), 32'(elem));
`else
        if (elem == 4'hF) verifica("elem_invalido", 32'(elem), 32'd0);
`endif
        botoes = val;
        sb.push_back('{estado: esp_estado, igual: esp_igual, ciclo: ciclo + 3});
        ciclos(1);
        botoes = 4'b0000;
        while (sb.size() != 0 && n < 10) begin
            ciclos(1);
            n++;
        end
        if (sb.size() != 0) begin
            verifica("veredito_ausente", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic jogar_rodada(input int r);
        exibe_rodada(r);
        for (int j = 0; j <= r; j++) begin
            pressiona(seq[j], (j < r) ? 4'h8 : 4'h9, 1'b1, seq[j]);
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : estimulo
        int n;
        reset  = 1'b1;
        jogar  = 1'b0;
        botoes = 4'b0000;
        ciclos(2);
        aplica_reset("reset_inicial");

        // Full win over three rounds, then restart.
        inicia_jogo();
        for (int r = 0; r < 3; r++) jogar_rodada(r);
        espera_estado(4'hA, "espera_ganhou");
        verifica("fim_ganhou", {29'd0, pronto, ganhou, perdeu}, 32'b110);
        verifica("rodada_final", 32'(db_rodada), 32'd2);
        ciclos(3);
        verifica("ganhou_retido", {30'd0, pronto, ganhou}, 32'b11);
        inicia_jogo();
        ciclos(1);
        verifica("reinicio", {27'd0, db_rodada, pronto}, 32'd0);

        // Wrong button in round 1.
        jogar_rodada(0);
        exibe_rodada(1);
        pressiona(4'b0010, 4'h8, 1'b1, 4'b0010);
        pressiona(4'b0001, 4'hE, 1'b0, 4'b0100);
        verifica("perdeu_flags", {27'd0, pronto, perdeu, ganhou, db_timeout, db_igual}, 32'b11000);

        // Inactivity timeout.
        inicia_jogo();
        exibe_rodada(0);
        espera_estado(4'h5, "espera_timeout");
        n = 0;
        while (db_estado === 4'h5 && n < T_INATIVO + 10) begin
            ciclos(1);
            n++;
        end
        verifica("duracao_espera", n, T_INATIVO);
        verifica("timeout_flags", {29'd0, perdeu, db_timeout, pronto}, 32'b111);

        // Press on the expiry cycle beats the timeout.
        inicia_jogo();
        exibe_rodada(0);
        espera_estado(4'h5, "espera_limite");
        ciclos(T_INATIVO - 1);
        pressiona(4'b0010, 4'h9, 1'b1, 4'b0010);
        verifica("limite_sem_timeout", 32'(db_timeout), 32'd0);

`ifdef JOGO_EXIBE_SEQ_EN
        espera_estado(4'h2, "espera_exibe_reset");
        aplica_reset("reset_exibe_led");
`else
        aplica_reset("reset_inicia");
`endif

        // Reset in the middle of round 1 input.
        inicia_jogo();
        jogar_rodada(0);
        exibe_rodada(1);
        pressiona(4'b0010, 4'h8, 1'b1, 4'b0010);
        espera_estado(4'h5, "espera_jogada1");
        verifica("jogada_1", {24'd0, db_rodada, db_jogada}, 32'h11);
        aplica_reset("reset_espera");

        // Multi-button press never matches.
        inicia_jogo();
        exibe_rodada(0);
        pressiona(4'b0011, 4'hE, 1'b0, 4'b0010);
        verifica("multi_perdeu", {30'd0, perdeu, db_timeout}, 32'b10);

        // Button held from the start of the round yields no press.
        inicia_jogo();
        botoes = 4'b0010;
        exibe_rodada(0);
        espera_estado(4'h5, "espera_segurado");
        ciclos(3);
        verifica("segurado_sem_lance", 32'(db_estado), 32'd5);
        botoes = 4'b0000;
        ciclos(1);
        pressiona(4'b0010, 4'h9, 1'b1, 4'b0010);

        aplica_reset("reset_final");
        verifica("scoreboard_vazio", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_verif, n_falhas);
        $finish;
    end

endmodule

`default_nettype wire
